// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer driving an external program counter.
// Optional feature macro: FETCH_BRANCH_EN enables relative JUMP and JZ opcodes.
module fetch_sequencer (
    input  logic              clk,
    input  logic              clr,
    input  logic [15:0]       rom_data,
    input  logic              exec_ready,
    input  logic              zero,
    output logic signed [7:0] up,
    output logic              pc_clr,
    output logic              rom_rd,
    output logic [15:0]       ir,
    output logic              exec_valid,
    output logic              halted,
    output logic [2:0]        state
);

    localparam int unsigned OP_W = 4;
    localparam logic [OP_W-1:0] OP_HALT = 4'b0101;
`ifdef FETCH_BRANCH_EN
    localparam logic [OP_W-1:0] OP_JUMP = 4'b0110;
    localparam logic [OP_W-1:0] OP_JZ   = 4'b0111;
`endif

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;
    logic [15:0]     ir_nxt;
    logic [OP_W-1:0] opcode;

    assign state  = 3'(cur_state);
    assign opcode = ir[15:12];

`ifndef FETCH_BRANCH_EN
    logic unused_zero;
    assign unused_zero = zero;
`endif

    // Next state, ir load and the single-cycle pc increment on accept.
    // INIT stays one extra cycle after reset so pc_clr is seen by the counter.
    always_comb begin
        nxt_state = cur_state;
        ir_nxt    = ir;
        up        = 8'sd0;
        case (cur_state)
            S_INIT:   nxt_state = pc_clr ? S_FETCH : S_INIT;
            S_FETCH:  nxt_state = S_DECODE;
            S_DECODE: begin
                ir_nxt    = rom_data;
                nxt_state = S_EXEC;
            end
            S_EXEC: begin
                if (exec_ready) begin
                    if (opcode == OP_HALT) begin
                        nxt_state = S_HALT;
                    end else begin
                        nxt_state = S_FETCH;
                        up        = 8'sd1;
`ifdef FETCH_BRANCH_EN
                        if (opcode == OP_JUMP || (opcode == OP_JZ && zero))
                            up = signed'(ir[7:0]);
`endif
                    end
                end
            end
            S_HALT:   nxt_state = S_HALT;
            default:  nxt_state = S_INIT;
        endcase
    end

    // State register; strobes are registered to line up with the state they decode.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur_state  <= S_INIT;
            ir         <= 16'd0;
            pc_clr     <= 1'b0;
            rom_rd     <= 1'b0;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            ir         <= ir_nxt;
            pc_clr     <= (nxt_state == S_INIT);
            rom_rd     <= (nxt_state == S_FETCH);
            exec_valid <= (nxt_state == S_EXEC);
            halted     <= (nxt_state == S_HALT);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: external pc counter and ROM plus an
// instruction-level reference model of program flow.
module tb_fetch_sequencer;

    logic              clk = 1'b0;
    logic              clr;
    logic [15:0]       rom_data;
    logic              exec_ready;
    logic              zero;
    logic signed [7:0] up;
    logic              pc_clr;
    logic              rom_rd;
    logic [15:0]       ir;
    logic              exec_valid;
    logic              halted;
    logic [2:0]        state;

    fetch_sequencer dut (
        .clk(clk), .clr(clr), .rom_data(rom_data), .exec_ready(exec_ready),
        .zero(zero), .up(up), .pc_clr(pc_clr), .rom_rd(rom_rd), .ir(ir),
        .exec_valid(exec_valid), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [128];
    logic [6:0]  pc = 7'd0;

    // Program counter and synchronous ROM around the sequencer
    always @(posedge clk) begin
        if (pc_clr) pc <= 7'd0;
        else        pc <= pc + 7'(up);
        if (rom_rd) rom_data <= rom[pc];
    end

    int n_checks = 0;
    int n_errors = 0;
    int model_pc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural pc delta of an accepted instruction
    function automatic int exp_delta(input logic [15:0] w, input logic z);
        case (w[15:12])
            4'h5: return 0;
`ifdef FETCH_BRANCH_EN
            4'h6: return int'($signed(w[7:0]));
            4'h7: return z ? int'($signed(w[7:0])) : 1;
`endif
            default: return 1;
        endcase
    endfunction

    task automatic do_reset();
        clr = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_up", {24'd0, up}, 32'd0);
        check("rst_flags", {28'd0, exec_valid, rom_rd, halted, pc_clr}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        model_pc = 0;
    endtask

    task automatic wait_exec(output bit ok);
        int guard = 0;
        exec_ready = 1'b0;
        while (!exec_valid && guard < 12) begin
            if (rom_rd) check("fetch_addr", 32'(pc), 32'(model_pc));
            zero = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        ok = exec_valid;
        if (!ok) check("exec_timeout", 32'(exec_valid), 32'd1);
    endtask

    task automatic exec_one(input int stall, input logic z,
                            output logic [15:0] w, output logic [7:0] u);
        bit ok;
        int d;
        w = rom[model_pc];
        u = 8'hxx;
        wait_exec(ok);
        if (!ok) return;
        check("ir", 32'(ir), 32'(w));
        for (int i = 0; i < stall; i++) begin
            check("stall_up", {24'd0, up}, 32'd0);
            check("stall_valid", 32'(exec_valid), 32'd1);
            check("ir_hold", 32'(ir), 32'(w));
            zero = 1'($urandom);
            @(negedge clk);
        end
        exec_ready = 1'b1;
        zero = z;
        #1;
        d = exp_delta(w, z);
        check("accept_up", {24'd0, up}, {24'd0, 8'(d)});
        u = up;
        @(negedge clk);
        exec_ready = 1'b0;
        model_pc = (model_pc + d) & 127;
        if (w[15:12] == 4'h5) begin
            for (int i = 0; i < 5; i++) begin
                check("halt_state", {24'd0, halted, exec_valid, rom_rd, pc_clr, 1'b0, state},
                      {24'd0, 1'b1, 3'b000, 1'b0, 3'd4});
                check("halt_up", {24'd0, up}, 32'd0);
                check("halt_ir", 32'(ir), 32'(w));
                exec_ready = 1'($urandom);
                zero = 1'($urandom);
                @(negedge clk);
            end
            exec_ready = 1'b0;
            do_reset();
        end else begin
            check("post_accept", {29'd0, exec_valid, state == 3'd1, halted}, 32'd2);
        end
    endtask

    task automatic mid_exec_reset();
        bit ok;
        wait_exec(ok);
        zero = 1'b1;
        exec_ready = 1'b1;
        do_reset();
        exec_ready = 1'b0;
    endtask

    logic [15:0] w;
    logic [7:0]  u;

    initial begin
        clr = 1'b1;
        exec_ready = 1'b0;
        zero = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 16'h3000;
        do_reset();

        // First instruction with exec_ready already high: three-cycle minimum
        exec_ready = 1'b1;
        @(negedge clk);
        check("init_pc_clr", {29'd0, pc_clr, state}, {29'd0, 1'b1, 3'd0});
        @(negedge clk);
        check("fetch_rd", {28'd0, rom_rd, pc_clr, state[1:0]}, {28'd0, 1'b1, 1'b0, 2'd1});
        @(negedge clk);
        check("decode", 32'(state), 32'd2);
        @(negedge clk);
        check("exec_first", {exec_valid, 3'(state), ir, up}, {1'b1, 3'd3, 16'h3000, 8'd1});
        @(negedge clk);
        check("after_first", {28'd0, exec_valid, 3'(state)}, {28'd0, 1'b0, 3'd1});
        check("pc_one", 32'(pc), 32'd1);
        exec_ready = 1'b0;
        model_pc = 1;

        // Stalled execute, then jumps forward and back
        rom[5] = 16'h6003;
        rom[8] = 16'h60FD;
        exec_one(4, 1'b0, w, u);
        check("stall_accept_up", 32'(u), 32'd1);
        for (int i = 0; i < 3; i++) exec_one(0, 1'b0, w, u);
        exec_one(1, 1'b0, w, u);
`ifdef FETCH_BRANCH_EN
        check("jump_fwd", 32'(u), 32'd3);
        check("jump_target", 32'(model_pc), 32'd8);
        exec_one(0, 1'b0, w, u);
        check("jump_back", 32'(u), 32'hFD);
        check("jump_back_target", 32'(model_pc), 32'd5);
`else
        check("jump_seq", 32'(u), 32'd1);
`endif
        exec_one(0, 1'b0, w, u);

        // Conditional jump on both zero values
        do_reset();
        rom[0] = 16'h7004;
        rom[1] = 16'h7004;
        exec_one(0, 1'b0, w, u);
        check("jz_not_taken", 32'(u), 32'd1);
        exec_one(2, 1'b1, w, u);
`ifdef FETCH_BRANCH_EN
        check("jz_taken", 32'(u), 32'd4);
`else
        check("jz_seq", 32'(u), 32'd1);
`endif
        exec_one(0, 1'b0, w, u);

        // Zero-offset loop and wrap through address 127
        do_reset();
        rom[0] = 16'h60FF;
        rom[127] = 16'h6002;
        rom[1] = 16'h6000;
        for (int i = 0; i < 5; i++) exec_one(0, 1'b1, w, u);

        // Halt holds, then reset abandons an execute in progress
        do_reset();
        rom[0] = 16'h5000;
        exec_one(1, 1'b0, w, u);
        rom[0] = 16'h3000;
        mid_exec_reset();
        exec_one(0, 1'b0, w, u);

        // Randomized programs against the reference model
        for (int i = 0; i < 128; i++) begin
            int r;
            logic [3:0] op;
            logic [7:0] off;
            r = $urandom_range(0, 15);
            if (r < 1)      op = 4'h5;
            else if (r < 5) op = 4'h6;
            else if (r < 8) op = 4'h7;
            else begin
                op = 4'($urandom_range(0, 15));
                if (op >= 4'h5 && op <= 4'h7) op = op + 4'd3;
            end
            off = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            rom[i] = {op, 4'($urandom), off};
        end
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) mid_exec_reset();
            else exec_one(int'($urandom_range(0, 3)), 1'($urandom), w, u);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 rom_data  input  16  instruction word from the synchronous instruction ROM; valid one cycle after rom_rd.
REQ-005 exec_ready  input  1  datapath accepts the current instruction this cycle.
REQ-006 zero  input  1  datapath zero flag; sampled only in the EXEC accept cycle.
REQ-007 up  output  8 signed  increment to the program counter; applied by the counter every clock.
REQ-008 pc_clr  output  1  synchronous clear request to the program counter.
REQ-009 rom_rd  output  1  instruction ROM read strobe at the counter's current address.
REQ-010 ir  output  16  instruction register.
REQ-011 exec_valid  output  1  ir holds an instruction awaiting datapath acceptance.
REQ-012 halted  output  1  sequencer has stopped.
REQ-013 state  output  3  current FSM state encoding, for debug.

Function
REQ-014 The FSM SHALL have exactly the states INIT=0, FETCH=1, DECODE=2, EXEC=3 and HALT=4.
REQ-015 INIT SHALL assert pc_clr=1 and up=0 for one cycle, then go to FETCH.
REQ-016 FETCH SHALL assert rom_rd=1 with up=0, then go to DECODE.
REQ-017 DECODE SHALL load ir<=rom_data with up=0, then go to EXEC.
REQ-018 EXEC SHALL hold exec_valid=1, hold ir stable and hold up=0 while exec_ready=0.
REQ-019 In the EXEC cycle with exec_ready=1 (the accept cycle), up SHALL be nonzero for that single cycle only, and the next state SHALL be FETCH.
REQ-020 Opcode ir[15:12]: 0101=HALT, 0110=JUMP, 0111=JZ; every other opcode SHALL be sequential and drive up=+1 on accept.
REQ-021 HALT on accept SHALL drive up=0, go to HALT and leave ir unchanged.
REQ-022 The HALT state SHALL hold halted=1, exec_valid=0, up=0 and rom_rd=0, and SHALL ignore all inputs until clr.
REQ-023 JUMP on accept SHALL drive up = ir[7:0], interpreted as signed and relative to the current instruction's address.
REQ-024 JZ on accept SHALL drive up=ir[7:0] if zero=1, otherwise up=+1.
REQ-025 A JUMP/JZ offset of 0 SHALL re-fetch the same address, which is a legal infinite loop.
REQ-026 Target addresses wrap modulo 128, with no detection or flagging.
REQ-027 One instruction SHALL complete in a minimum of 3 cycles: FETCH, DECODE, and EXEC with exec_ready already 1.
REQ-028 exec_valid SHALL be 1 only in EXEC.
REQ-029 pc_clr SHALL be 1 only in INIT.
REQ-030 rom_rd SHALL be 1 only in FETCH.
REQ-031 halted SHALL be 1 only in HALT.
REQ-032 exec_ready and zero SHALL be ignored outside EXEC.

Reset
REQ-033 clr=1 SHALL asynchronously force state=INIT, ir=0, up=0, exec_valid=0, rom_rd=0, halted=0 and pc_clr=0.
REQ-034 Reset asserted in any state, including mid-EXEC or HALT, SHALL abandon the instruction; no up pulse SHALL be emitted.
REQ-035 After clr deasserts, the first rising edge SHALL enter INIT behaviour (pc_clr=1), then FETCH from address 0.

Configuration
REQ-036 Macro FETCH_BRANCH_EN defined: JUMP and JZ SHALL behave per REQ-023 and REQ-024.
REQ-037 Macro FETCH_BRANCH_EN undefined: opcodes 0110 and 0111 SHALL be sequential (up=+1), the zero input SHALL be unused, and the offset logic SHALL be absent.

Verification
REQ-038 Release clr; ROM[0]=0x3000, exec_ready=1 -> pc_clr pulse, rom_rd next cycle, ir=0x3000, exec_valid for 1 cycle, up=+1 for 1 cycle; counter address = 1.
REQ-039 ir=0x3000, exec_ready=0 for 4 cycles then 1 -> exec_valid high 5 cycles, ir constant, up=0 until the accept cycle, then up=+1 once.
REQ-040 Address 5 holds 0x6003 -> up=+3 once, next fetch at address 8; address 8 holds 0x60FD -> up=-3, next fetch at address 5.
REQ-041 JZ 0x7004 with zero=0 -> up=+1; repeat with zero=1 -> up=+4.
REQ-042 Build without FETCH_BRANCH_EN: 0x6003 -> up=+1.
REQ-043 HALT 0x5000 accepted -> halted=1, up=0 indefinitely, toggling exec_ready and zero has no effect; clr asserted mid-EXEC -> immediate INIT outputs and no up pulse.
